motor_cmd_parser: RTL and testbench

- Byte-level command parser that sits directly upstream of the six-channel motor enable stage.
- Consumes a received-byte stream (rx_data/rx_valid from the serial receiver) and assembles 4-byte command frames.
- Validates each frame and drives the motor index / state pair that the enable stage samples every clock.
- Holds outputs between commands, and reports rejected frames and inter-byte timeouts.

---
 rtl/motor_cmd_parser_if.sv | 21 ++
 rtl/motor_cmd_parser.sv | 116 +++++++++++
 tb/tb_motor_cmd_parser.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/motor_cmd_parser_if.sv
// Byte stream in, motor command and error status out.
// The master drives received bytes; the slave is the parser.
interface motor_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] motor;
    logic [1:0] state;
    logic       cmd_strobe;
    logic       frame_error;
    logic [7:0] err_count;

    modport master (
        output rx_data, rx_valid,
        input  motor, state, cmd_strobe, frame_error, err_count
    );

    modport slave (
        input  rx_data, rx_valid,
        output motor, state, cmd_strobe, frame_error, err_count
    );
endinterface

// File: rtl/motor_cmd_parser.sv
// Assembles HEADER,M,S,C frames and drives the registered motor/state pair.
// Rejected frames and inter-byte timeouts pulse frame_error.
module motor_cmd_parser #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         NUM_MOTORS     = 6,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] IDLE_MOTOR     = 8'hFF
) (
    input logic              clock,
    input logic              reset,
    motor_cmd_parser_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOTOR,
        S_STATE,
        S_CHK
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    m_q, m_d;
    logic [7:0]    s_q, s_d;
    logic [7:0]    motor_q, motor_d;
    logic [1:0]    st_q, st_d;
    logic          strobe_q, strobe_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    err_q, err_d;
    logic          accept;
    logic          timeout;

    assign accept = (bus.rx_data == 8'(m_q + s_q))
                 && (m_q < 8'(NUM_MOTORS))
                 && (s_q[7:2] == 6'd0);

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (fsm_q != S_IDLE) && !bus.rx_valid && (cnt_q == CNT_LAST);

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        m_d      = m_q;
        s_d      = s_q;
        motor_d  = motor_q;
        st_d     = st_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        if (bus.rx_valid) begin
            cnt_d = '0;
            unique case (fsm_q)
                S_IDLE: begin
                    if (bus.rx_data == HEADER) fsm_d = S_MOTOR;
                end
                S_MOTOR: begin
                    m_d   = bus.rx_data;
                    fsm_d = S_STATE;
                end
                S_STATE: begin
                    s_d   = bus.rx_data;
                    fsm_d = S_CHK;
                end
                S_CHK: begin
                    fsm_d = S_IDLE;
                    if (accept) begin
                        motor_d  = m_q;
                        st_d     = s_q[1:0];
                        strobe_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end else if (timeout) begin
            fsm_d  = S_IDLE;
            cnt_d  = '0;
            ferr_d = 1'b1;
        end else if (fsm_q != S_IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = (ferr_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            cnt_q    <= '0;
            m_q      <= 8'd0;
            s_q      <= 8'd0;
            motor_q  <= IDLE_MOTOR;
            st_q     <= 2'b00;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            err_q    <= 8'd0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            s_q      <= s_d;
            motor_q  <= motor_d;
            st_q     <= st_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
            err_q    <= err_d;
        end
    end

    assign bus.motor       = motor_q;
    assign bus.state       = st_q;
    assign bus.cmd_strobe  = strobe_q;
    assign bus.frame_error = ferr_q;
    assign bus.err_count   = err_q;
endmodule

// File: tb/tb_motor_cmd_parser.sv
// Directed bench for motor_cmd_parser with a 16-cycle timeout.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_motor_cmd_parser;
    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;

    motor_cmd_parser_if bus ();

    motor_cmd_parser #(
        .HEADER        (8'hA5),
        .NUM_MOTORS    (6),
        .TIMEOUT_CYCLES(16),
        .IDLE_MOTOR    (8'hFF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.cmd_strobe !== 1'b0 || bus.frame_error !== 1'b0) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_idle_pulses: got %0d pulse cycles want 0", bad);
        end
        n_chk++;
        if (bus.motor !== 8'hFF || bus.state !== 2'b00 || bus.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: got motor=%0h state=%0h err=%0d want ff 0 0",
                     bus.motor, bus.state, bus.err_count);
        end
    endtask

    task automatic test_accept();
        send3(8'hA5, 8'h02, 8'h01);
        n_chk++;
        if (bus.cmd_strobe !== 1'b0 || bus.motor !== 8'hFF) begin
            n_fail++;
            $display("FAIL accept_early: got strobe=%0b motor=%0h want 0 ff",
                     bus.cmd_strobe, bus.motor);
        end
        send_byte(8'h03);
        n_chk++;
        if (bus.motor !== 8'h02 || bus.state !== 2'b01 || bus.cmd_strobe !== 1'b1
            || bus.frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_out: got motor=%0h state=%0h strobe=%0b ferr=%0b want 2 1 1 0",
                     bus.motor, bus.state, bus.cmd_strobe, bus.frame_error);
        end
        tick();
        n_chk++;
        if (bus.cmd_strobe !== 1'b0 || bus.motor !== 8'h02 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL accept_hold: got strobe=%0b motor=%0h state=%0h want 0 2 1",
                     bus.cmd_strobe, bus.motor, bus.state);
        end
    endtask

    task automatic test_reject();
        send3(8'hA5, 8'h07, 8'h01);
        send_byte(8'h08);
        n_chk++;
        if (bus.frame_error !== 1'b1 || bus.cmd_strobe !== 1'b0 || bus.err_count !== 8'd1
            || bus.motor !== 8'h02 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL reject_motor: got ferr=%0b strobe=%0b err=%0d motor=%0h state=%0h want 1 0 1 2 1",
                     bus.frame_error, bus.cmd_strobe, bus.err_count, bus.motor, bus.state);
        end
        tick();
        n_chk++;
        if (bus.frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_pulse_len: got ferr=%0b want 0", bus.frame_error);
        end
        send3(8'hA5, 8'h01, 8'h01);
        send_byte(8'h05);
        n_chk++;
        if (bus.frame_error !== 1'b1 || bus.err_count !== 8'd2
            || bus.motor !== 8'h02 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL reject_chk: got ferr=%0b err=%0d motor=%0h state=%0h want 1 2 2 1",
                     bus.frame_error, bus.err_count, bus.motor, bus.state);
        end
        send3(8'hA5, 8'h01, 8'h04);
        send_byte(8'h05);
        n_chk++;
        if (bus.frame_error !== 1'b1 || bus.err_count !== 8'd3 || bus.motor !== 8'h02) begin
            n_fail++;
            $display("FAIL reject_state: got ferr=%0b err=%0d motor=%0h want 1 3 2",
                     bus.frame_error, bus.err_count, bus.motor);
        end
        send3(8'hA5, 8'h05, 8'h03);
        send_byte(8'h08);
        n_chk++;
        if (bus.cmd_strobe !== 1'b1 || bus.motor !== 8'h05 || bus.state !== 2'b11
            || bus.err_count !== 8'd3) begin
            n_fail++;
            $display("FAIL accept_max: got strobe=%0b motor=%0h state=%0h err=%0d want 1 5 3 3",
                     bus.cmd_strobe, bus.motor, bus.state, bus.err_count);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.frame_error !== 1'b0) early++;
        end
        n_chk++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL timeout_early: got %0d early pulses want 0", early);
        end
        tick();
        n_chk++;
        if (bus.frame_error !== 1'b1 || bus.err_count !== 8'd4 || bus.motor !== 8'h05) begin
            n_fail++;
            $display("FAIL timeout_fire: got ferr=%0b err=%0d motor=%0h want 1 4 5",
                     bus.frame_error, bus.err_count, bus.motor);
        end
        send3(8'hA5, 8'h03, 8'h00);
        send_byte(8'h03);
        n_chk++;
        if (bus.cmd_strobe !== 1'b1 || bus.motor !== 8'h03 || bus.state !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_recover: got strobe=%0b motor=%0h state=%0h want 1 3 0",
                     bus.cmd_strobe, bus.motor, bus.state);
        end
    endtask

    task automatic test_byte_wins();
        send_byte(8'hA5);
        for (int i = 0; i < 15; i++) tick();
        send_byte(8'h01);
        n_chk++;
        if (bus.frame_error !== 1'b0 || bus.err_count !== 8'd4) begin
            n_fail++;
            $display("FAIL byte_wins: got ferr=%0b err=%0d want 0 4",
                     bus.frame_error, bus.err_count);
        end
        send_byte(8'h00);
        send_byte(8'h01);
        n_chk++;
        if (bus.cmd_strobe !== 1'b1 || bus.motor !== 8'h01 || bus.state !== 2'b00) begin
            n_fail++;
            $display("FAIL byte_wins_frame: got strobe=%0b motor=%0h state=%0h want 1 1 0",
                     bus.cmd_strobe, bus.motor, bus.state);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        send_byte(8'h00);
        if (bus.frame_error !== 1'b0 || bus.cmd_strobe !== 1'b0) bad++;
        send_byte(8'h11);
        if (bus.frame_error !== 1'b0 || bus.cmd_strobe !== 1'b0) bad++;
        send_byte(8'hA4);
        if (bus.frame_error !== 1'b0 || bus.cmd_strobe !== 1'b0) bad++;
        send3(8'hA5, 8'h00, 8'h01);
        if (bus.frame_error !== 1'b0 || bus.cmd_strobe !== 1'b0) bad++;
        n_chk++;
        if (bad != 0 || bus.err_count !== 8'd4) begin
            n_fail++;
            $display("FAIL junk_ignored: got bad=%0d err=%0d want 0 4", bad, bus.err_count);
        end
        send_byte(8'h01);
        n_chk++;
        if (bus.cmd_strobe !== 1'b1 || bus.motor !== 8'h00 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_accept: got strobe=%0b motor=%0h state=%0h want 1 0 1",
                     bus.cmd_strobe, bus.motor, bus.state);
        end
        send3(8'hA5, 8'hA5, 8'h00);
        send_byte(8'hA5);
        n_chk++;
        if (bus.frame_error !== 1'b1 || bus.err_count !== 8'd5 || bus.motor !== 8'h00) begin
            n_fail++;
            $display("FAIL header_as_data: got ferr=%0b err=%0d motor=%0h want 1 5 0",
                     bus.frame_error, bus.err_count, bus.motor);
        end
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'h05);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_chk++;
        if (bus.motor !== 8'hFF || bus.state !== 2'b00 || bus.err_count !== 8'd0
            || bus.cmd_strobe !== 1'b0 || bus.frame_error !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset: got motor=%0h state=%0h err=%0d want ff 0 0",
                     bus.motor, bus.state, bus.err_count);
        end
        send_byte(8'h01);
        send_byte(8'h06);
        tick();
        n_chk++;
        if (bus.motor !== 8'hFF || bus.cmd_strobe !== 1'b0 || bus.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL stale_bytes: got motor=%0h strobe=%0b err=%0d want ff 0 0",
                     bus.motor, bus.cmd_strobe, bus.err_count);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 254; i++) begin
            send3(8'hA5, 8'h07, 8'h00);
            send_byte(8'h07);
        end
        n_chk++;
        if (bus.err_count !== 8'd254) begin
            n_fail++;
            $display("FAIL sat_254: got %0d want 254", bus.err_count);
        end
        send3(8'hA5, 8'h07, 8'h00);
        send_byte(8'h07);
        n_chk++;
        if (bus.err_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_255: got %0d want 255", bus.err_count);
        end
        for (int i = 0; i < 45; i++) begin
            send3(8'hA5, 8'h07, 8'h00);
            send_byte(8'h07);
        end
        n_chk++;
        if (bus.err_count !== 8'hFF || bus.frame_error !== 1'b1 || bus.motor !== 8'hFF) begin
            n_fail++;
            $display("FAIL sat_hold: got err=%0d ferr=%0b motor=%0h want 255 1 ff",
                     bus.err_count, bus.frame_error, bus.motor);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        test_reset();
        test_accept();
        test_reject();
        test_timeout();
        test_byte_wins();
        test_back_to_back();
        test_reset_midframe();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
